riscv_mem_arbiter: RTL and testbench
====================================

Name: riscv_mem_arbiter

Overview:
Shares one single-port unified memory between the pipeline's instruction-fetch port and its data-memory port. It arbitrates between the two requesters, sequences each transaction over a req/ack memory handshake, and returns read data with a one-cycle valid pulse. It also drives per-port stall signals so the hazard unit can freeze the pipeline. A starvation counter guarantees forward progress for fetch, and a timeout watchdog guards against a hung memory.

Parameters:
MP_DATA_WIDTH, 32, data bus width
MP_ADDR_WIDTH, 32, address width
MP_MAX_DM_STREAK, 4, consecutive data grants allowed while a fetch is pending; must be at least 1
MP_TIMEOUT, 255, maximum BUSY cycles waiting for ack before abort; must be at least 1

Ports:
iclk  in  1  clock, rising edge
irst_n  in  1  asynchronous active-low reset
iif_req  in  1  fetch request; held high with iif_addr until oif_valid
iif_addr  in  MP_ADDR_WIDTH  fetch address
oif_rdata  out  MP_DATA_WIDTH  fetched instruction; valid only with oif_valid
oif_valid  out  1  one-cycle fetch completion pulse
ostall_if  out  1  iif_req & ~oif_valid
idm_req  in  1  data request; held high with all idm_* inputs until odm_valid
idm_wr_en  in  1  1 = write, 0 = read
idm_wr_be  in  2  byte-enable/size code, passed through unchanged
idm_addr  in  MP_ADDR_WIDTH  data address
idm_wr_data  in  MP_DATA_WIDTH  write data
odm_rdata  out  MP_DATA_WIDTH  read data; valid only with odm_valid
odm_valid  out  1  one-cycle data completion pulse (reads and writes)
ostall_dm  out  1  idm_req & ~odm_valid
omem_req  out  1  memory request, held until ack
omem_addr  out  MP_ADDR_WIDTH  registered address
omem_wr_en  out  1  registered write enable; 0 for fetches
omem_wr_be  out  2  registered byte-enable code; 0 for fetches
omem_wr_data  out  MP_DATA_WIDTH  registered write data
imem_ack  in  1  memory completion, sampled on iclk
imem_rd_data  in  MP_DATA_WIDTH  memory read data, valid with imem_ack
otimeout  out  1  one-cycle pulse when a transaction is aborted

Behaviour:
- Reset (asynchronous, irst_n=0):
  - All registered outputs go to 0 immediately, including omem_req.
  - FSM goes to IDLE; streak and timeout counters clear.
  - An in-flight transaction is discarded and no valid pulse is produced.
- FSM states: IDLE, IF_BUSY, DM_BUSY.
- IDLE arbitration, evaluated each cycle:
  - Only iif_req: grant fetch, go to IF_BUSY.
  - Only idm_req: grant data, go to DM_BUSY.
  - Both: data wins unless streak == MP_MAX_DM_STREAK, in which case fetch wins.
  - Neither: stay in IDLE.
- On grant: the request fields are registered onto omem_* and omem_req=1 from the next cycle. Fetch grants drive omem_wr_en=0 and omem_wr_be=0.
- Streak counter:
  - Increments on each data grant made while iif_req=1; saturates at MP_MAX_DM_STREAK.
  - Clears on any fetch grant, and on a data grant while iif_req=0.
- BUSY states:
  - omem_* are held stable while imem_ack=0.
  - When imem_ack=1 is sampled: omem_req drops, imem_rd_data is captured into oif_rdata or odm_rdata, the matching valid pulses high for exactly the next cycle, and the FSM returns to IDLE.
  - For writes, odm_rdata is loaded with 0.
- Latency: a request seen in IDLE at cycle 0 gives omem_req at cycle 1. With ack at cycle 1, valid appears at cycle 2, which is the minimum. Each extra cycle of ack delay adds one cycle.
- Back-to-back: during the valid cycle the FSM is in IDLE and may grant again. The completed port's request is masked from arbitration in that cycle, because the requester drops or changes its request only after seeing valid.
- rdata registers hold their value until the next completion on the same port.
- Timeout:
  - The counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches MP_TIMEOUT: omem_req drops, the matching valid and otimeout pulse for one cycle, rdata loads 0, and the FSM returns to IDLE.
  - If ack arrives in the same cycle the count reaches MP_TIMEOUT, the ack wins and otimeout stays 0.
- Stall outputs are combinational. Each is 0 in the port's valid cycle and 0 whenever that port is idle.
- imem_ack while in IDLE is ignored.

Test Plan:
- Single fetch, iif_addr=0x100, memory acks on the first omem_req cycle with 0x00500093 -> omem_req high cycle 1 only; oif_valid=1 and oif_rdata=0x00500093 at cycle 2; ostall_if high cycles 0-1.
- Data write, addr=0x2000, data=0xDEADBEEF, be=2'b10, ack delayed 3 cycles -> omem_* stable for 4 cycles; odm_valid pulse at cycle 5; odm_rdata=0.
- Both ports requesting continuously, MP_MAX_DM_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Memory never acks, MP_TIMEOUT=8 -> omem_req drops after 8 BUSY cycles; otimeout and odm_valid pulse together; odm_rdata=0; the FSM then serves a pending fetch.
- irst_n asserted mid-DM_BUSY -> omem_req=0 immediately; no valid pulse; after release the held request is re-granted with latency 2.
- imem_ack arrives in the same cycle the timeout count reaches MP_TIMEOUT -> normal completion, otimeout=0, rdata equals imem_rd_data.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | riscv_mem_arbiter: fetch/data arbiter for one shared single-port memory   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module riscv_mem_arbiter #(
  parameter int MP_DATA_WIDTH    = 32,
  parameter int MP_ADDR_WIDTH    = 32,
  parameter int MP_MAX_DM_STREAK = 4,
  parameter int MP_TIMEOUT       = 255
) (
  input  logic                     iclk,
  input  logic                     irst_n,
  input  logic                     iif_req,
  input  logic [MP_ADDR_WIDTH-1:0] iif_addr,
  output logic [MP_DATA_WIDTH-1:0] oif_rdata,
  output logic                     oif_valid,
  output logic                     ostall_if,
  input  logic                     idm_req,
  input  logic                     idm_wr_en,
  input  logic [1:0]               idm_wr_be,
  input  logic [MP_ADDR_WIDTH-1:0] idm_addr,
  input  logic [MP_DATA_WIDTH-1:0] idm_wr_data,
  output logic [MP_DATA_WIDTH-1:0] odm_rdata,
  output logic                     odm_valid,
  output logic                     ostall_dm,
  output logic                     omem_req,
  output logic [MP_ADDR_WIDTH-1:0] omem_addr,
  output logic                     omem_wr_en,
  output logic [1:0]               omem_wr_be,
  output logic [MP_DATA_WIDTH-1:0] omem_wr_data,
  input  logic                     imem_ack,
  input  logic [MP_DATA_WIDTH-1:0] imem_rd_data,
  output logic                     otimeout
);

  localparam int c_STREAK_W = $clog2(MP_MAX_DM_STREAK + 1);
  localparam int c_TMO_W    = $clog2(MP_TIMEOUT + 1);
  localparam logic [c_STREAK_W-1:0] c_MAX_STREAK = c_STREAK_W'(MP_MAX_DM_STREAK);
  localparam logic [c_TMO_W-1:0]    c_TMO_LAST   = c_TMO_W'(MP_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t                  r_state;
  logic [c_STREAK_W-1:0]   r_streak;
  logic [c_TMO_W-1:0]      r_tcnt;

  logic w_if_req;
  logic w_dm_req;
  logic w_pick_dm;
  logic w_expire;

  // A port that is completing this cycle is masked: its requester still
  // holds the old request until it has seen the valid pulse.
  assign w_if_req  = iif_req & ~oif_valid;
  assign w_dm_req  = idm_req & ~odm_valid;
  assign w_pick_dm = w_dm_req & (~w_if_req | (r_streak != c_MAX_STREAK));
  assign w_expire  = (r_tcnt == c_TMO_LAST);

  assign ostall_if = w_if_req;
  assign ostall_dm = w_dm_req;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      r_state      <= IDLE;
      r_streak     <= '0;
      r_tcnt       <= '0;
      omem_req     <= 1'b0;
      omem_addr    <= '0;
      omem_wr_en   <= 1'b0;
      omem_wr_be   <= 2'b00;
      omem_wr_data <= '0;
      oif_rdata    <= '0;
      oif_valid    <= 1'b0;
      odm_rdata    <= '0;
      odm_valid    <= 1'b0;
      otimeout     <= 1'b0;
    end else begin
      oif_valid <= 1'b0;
      odm_valid <= 1'b0;
      otimeout  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_dm) begin
            r_state      <= DM_BUSY;
            r_tcnt       <= '0;
            omem_req     <= 1'b1;
            omem_addr    <= idm_addr;
            omem_wr_en   <= idm_wr_en;
            omem_wr_be   <= idm_wr_be;
            omem_wr_data <= idm_wr_data;
            if (iif_req) begin
              if (r_streak != c_MAX_STREAK) r_streak <= r_streak + 1'b1;
            end else begin
              r_streak <= '0;
            end
          end else if (w_if_req) begin
            r_state      <= IF_BUSY;
            r_tcnt       <= '0;
            r_streak     <= '0;
            omem_req     <= 1'b1;
            omem_addr    <= iif_addr;
            omem_wr_en   <= 1'b0;
            omem_wr_be   <= 2'b00;
            omem_wr_data <= '0;
          end
        end
        IF_BUSY, DM_BUSY: begin
          // An ack on the last allowed cycle still completes normally.
          if (imem_ack || w_expire) begin
            r_state  <= IDLE;
            omem_req <= 1'b0;
            otimeout <= ~imem_ack;
            if (r_state == IF_BUSY) begin
              oif_valid <= 1'b1;
              oif_rdata <= imem_ack ? imem_rd_data : '0;
            end else begin
              odm_valid <= 1'b1;
              odm_rdata <= (imem_ack && !omem_wr_en) ? imem_rd_data : '0;
            end
          end else begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_riscv_mem_arbiter: directed bench with a transaction-level model       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_riscv_mem_arbiter;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int MAXS = 4;
  localparam int TMO  = 8;
  localparam logic [31:0] NEVER_ADDR = 32'h0000BAD0;

  logic          iclk = 1'b0;
  logic          irst_n = 1'b0;
  logic          iif_req = 1'b0;
  logic [AW-1:0] iif_addr = '0;
  logic [DW-1:0] oif_rdata;
  logic          oif_valid;
  logic          ostall_if;
  logic          idm_req = 1'b0;
  logic          idm_wr_en = 1'b0;
  logic [1:0]    idm_wr_be = 2'b00;
  logic [AW-1:0] idm_addr = '0;
  logic [DW-1:0] idm_wr_data = '0;
  logic [DW-1:0] odm_rdata;
  logic          odm_valid;
  logic          ostall_dm;
  logic          omem_req;
  logic [AW-1:0] omem_addr;
  logic          omem_wr_en;
  logic [1:0]    omem_wr_be;
  logic [DW-1:0] omem_wr_data;
  logic          imem_ack = 1'b0;
  logic [DW-1:0] imem_rd_data = '0;
  logic          otimeout;

  int checks   = 0;
  int failures = 0;

  int            ack_delay = 0;
  int            req_age   = 0;
  logic [31:0]   rd_base   = 32'h00500093 - 32'h100;

  riscv_mem_arbiter #(
    .MP_DATA_WIDTH(DW), .MP_ADDR_WIDTH(AW),
    .MP_MAX_DM_STREAK(MAXS), .MP_TIMEOUT(TMO)
  ) dut (
    .iclk(iclk), .irst_n(irst_n),
    .iif_req(iif_req), .iif_addr(iif_addr), .oif_rdata(oif_rdata),
    .oif_valid(oif_valid), .ostall_if(ostall_if),
    .idm_req(idm_req), .idm_wr_en(idm_wr_en), .idm_wr_be(idm_wr_be),
    .idm_addr(idm_addr), .idm_wr_data(idm_wr_data), .odm_rdata(odm_rdata),
    .odm_valid(odm_valid), .ostall_dm(ostall_dm),
    .omem_req(omem_req), .omem_addr(omem_addr), .omem_wr_en(omem_wr_en),
    .omem_wr_be(omem_wr_be), .omem_wr_data(omem_wr_data),
    .imem_ack(imem_ack), .imem_rd_data(imem_rd_data), .otimeout(otimeout)
  );

  always #5 iclk = ~iclk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge iclk);
    #1;
  endtask

  // Memory: acks after ack_delay cycles of omem_req; NEVER_ADDR never acks.
  initial forever begin
    @(posedge iclk);
    #1;
    if (omem_req) begin
      imem_ack     = (omem_addr != NEVER_ADDR) && (req_age == ack_delay);
      imem_rd_data = rd_base + omem_addr;
      req_age++;
    end else begin
      imem_ack = 1'b0;
      req_age  = 0;
    end
  end

  // Transaction-level model: one outstanding transaction, counted wait cycles.
  logic          e_req = 0, e_we = 0, e_ifv = 0, e_dmv = 0, e_to = 0;
  logic [1:0]    e_be = 0;
  logic [AW-1:0] e_addr = 0;
  logic [DW-1:0] e_wdata = 0, e_ifrd = 0, e_dmrd = 0;
  bit            m_busy = 0, m_dm = 0, m_ifp = 0, m_dmp = 0, m_done = 0, m_abort = 0;
  int            m_wait = 0, m_streak = 0;

  initial forever begin
    @(posedge iclk or negedge irst_n);
    if (!irst_n) begin
      e_req = 0; e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0;
      e_ifrd = 0; e_dmrd = 0; e_ifv = 0; e_dmv = 0; e_to = 0;
      m_busy = 0; m_wait = 0; m_streak = 0;
    end else begin
      m_ifp = iif_req && !e_ifv;
      m_dmp = idm_req && !e_dmv;
      e_ifv = 0; e_dmv = 0; e_to = 0;
      m_done = 0; m_abort = 0;
      if (m_busy) begin
        if (imem_ack) m_done = 1;
        else begin
          m_wait++;
          if (m_wait >= TMO) begin m_done = 1; m_abort = 1; end
        end
        if (m_done) begin
          m_busy = 0; e_req = 0; e_to = m_abort;
          if (m_dm) begin
            e_dmv  = 1;
            e_dmrd = (m_abort || e_we) ? '0 : imem_rd_data;
          end else begin
            e_ifv  = 1;
            e_ifrd = m_abort ? '0 : imem_rd_data;
          end
        end
      end else if (m_dmp && (!m_ifp || m_streak < MAXS)) begin
        m_busy = 1; m_dm = 1; m_wait = 0; e_req = 1;
        e_addr = idm_addr; e_we = idm_wr_en; e_be = idm_wr_be; e_wdata = idm_wr_data;
        m_streak = iif_req ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
      end else if (m_ifp) begin
        m_busy = 1; m_dm = 0; m_wait = 0; e_req = 1;
        e_addr = iif_addr; e_we = 0; e_be = 0;
        m_streak = 0;
      end
    end
  end

  initial forever begin
    @(negedge iclk);
    check("req", omem_req, e_req);
    check("if_valid", oif_valid, e_ifv);
    check("dm_valid", odm_valid, e_dmv);
    check("timeout", otimeout, e_to);
    check("if_rdata", oif_rdata, e_ifrd);
    check("dm_rdata", odm_rdata, e_dmrd);
    check("stall_if", ostall_if, iif_req && !e_ifv);
    check("stall_dm", ostall_dm, idm_req && !e_dmv);
    if (e_req) begin
      check("addr", omem_addr, e_addr);
      check("wr_en", omem_wr_en, e_we);
      check("wr_be", omem_wr_be, e_be);
      if (e_we) check("wr_data", omem_wr_data, e_wdata);
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  bit exp_dm [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  bit is_dm;

  initial begin
    repeat (2) @(posedge iclk);
    #1;
    check("rst_req", omem_req, 0);
    check("rst_valids", {oif_valid, odm_valid, otimeout}, 0);
    check("rst_rdata", {oif_rdata, odm_rdata}, 0);
    irst_n = 1'b1;
    step();

    // Single fetch, ack in the first request cycle.
    ack_delay = 0;
    iif_addr = 32'h100; iif_req = 1;
    #1 check("t1_stall_c0", ostall_if, 1);
    step();
    check("t1_req_c1", omem_req, 1);
    check("t1_addr_c1", omem_addr, 32'h100);
    check("t1_stall_c1", ostall_if, 1);
    step();
    check("t1_valid_c2", oif_valid, 1);
    check("t1_rdata_c2", oif_rdata, 32'h00500093);
    check("t1_req_c2", omem_req, 0);
    check("t1_stall_c2", ostall_if, 0);
    iif_req = 0;
    step();
    check("t1_valid_c3", oif_valid, 0);

    // Data write, ack delayed by 3 cycles.
    ack_delay = 3;
    idm_addr = 32'h2000; idm_wr_data = 32'hDEADBEEF; idm_wr_be = 2'b10;
    idm_wr_en = 1; idm_req = 1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check("t2_hold", {omem_req, omem_wr_en, omem_wr_be, omem_addr, omem_wr_data},
            {1'b1, 1'b1, 2'b10, 32'h2000, 32'hDEADBEEF});
    end
    step();
    check("t2_valid_c5", odm_valid, 1);
    check("t2_rdata_c5", odm_rdata, 0);
    idm_req = 0; idm_wr_en = 0; idm_wr_be = 0;
    step();

    // Both ports request at each arbitration point; loser withdraws.
    ack_delay = 0;
    for (int k = 0; k < 10; k++) begin
      iif_addr = 32'h4000 + k; iif_req = 1;
      idm_addr = 32'h3000 + k; idm_req = 1;
      step();
      is_dm = (omem_addr[15:12] == 4'h3);
      check($sformatf("t3_grant%0d_is_dm", k), is_dm, exp_dm[k]);
      if (is_dm) iif_req = 0; else idm_req = 0;
      step();
      iif_req = 0; idm_req = 0;
      step();
    end

    // Hung memory on a data read while a fetch waits.
    idm_addr = NEVER_ADDR; idm_req = 1;
    iif_addr = 32'h500; iif_req = 1;
    for (int c = 1; c <= TMO; c++) begin
      step();
      check("t4_req_busy", {omem_req, omem_addr}, {1'b1, NEVER_ADDR});
    end
    step();
    check("t4_abort", {otimeout, odm_valid, omem_req}, 3'b110);
    check("t4_rdata", odm_rdata, 0);
    idm_req = 0;
    step();
    check("t4_fetch_grant", {omem_req, omem_addr}, {1'b1, 32'h500});
    step();
    check("t4_fetch_done", oif_valid, 1);
    iif_req = 0;
    step();

    // Asynchronous reset in the middle of a data transaction.
    ack_delay = 5;
    idm_addr = 32'h6000; idm_req = 1;
    step(); step();
    check("t5_busy", omem_req, 1);
    irst_n = 0;
    #1;
    check("t5_async_req", omem_req, 0);
    check("t5_no_valid", odm_valid, 0);
    step(); step();
    ack_delay = 0;
    irst_n = 1;
    step();
    check("t5_regrant", {omem_req, omem_addr}, {1'b1, 32'h6000});
    step();
    check("t5_valid", odm_valid, 1);
    check("t5_rdata", odm_rdata, rd_base + 32'h6000);
    idm_req = 0;
    step();

    // Ack arriving on the last allowed cycle wins over the timeout.
    ack_delay = TMO - 1;
    idm_addr = 32'h7000; idm_req = 1;
    repeat (TMO) step();
    check("t6_req_last", omem_req, 1);
    step();
    check("t6_done", {odm_valid, otimeout}, 2'b10);
    check("t6_rdata", odm_rdata, rd_base + 32'h7000);
    idm_req = 0;
    step();

    // Stray ack while idle.
    #1 imem_ack = 1;
    step();
    check("t7_idle_ack", {oif_valid, odm_valid, omem_req}, 3'b000);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
